// File: rtl/asic_rmr2_ctrl.sv
// Gate Array mode/ROM control: decodes Z80 writes to &7Fxx into the RMR register and,
// while ASIC features are unlocked, the RMR2 register; drives memory-map selects.
module asic_rmr2_ctrl #(
    parameter logic [4:0] RMR2_RESET = 5'b00000,
    parameter logic [1:0] ASIC_LOC   = 2'b11
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        ioreq_b,
    input  logic        wr_b,
    input  logic        mreq_b,
    input  logic [15:0] adr,
    input  logic [7:0]  data,
    input  logic        enf,
    output logic [1:0]  mode,
    output logic        lrom_dis,
    output logic        urom_dis,
    output logic        int_clr,
    output logic [1:0]  lrom_loc,
    output logic [2:0]  cart_page,
    output logic        asic_page_en,
    output logic        asic_cs
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        stb;
    logic        stb_q;
    logic        enf_q;
    logic        enf_s;
    logic [7:0]  data_q;
    logic [4:0]  rmr2;
    logic        capture;
    logic        rmr_wr;
    logic        rmr2_wr;
    logic        feat_on;
    logic        lock_edge;
    logic        asic_loc_hit;
    logic        adr_unused;

    assign stb          = ~ioreq_b & ~wr_b & (adr[15:14] == 2'b01);
    assign lock_edge    = enf_q & ~enf;
    // Features count as on only if unlocked both at sample time and at commit, so a
    // lock arriving mid-write turns an RMR2-looking byte into an RMR write.
    assign feat_on      = enf_s & enf;
    assign adr_unused   = ^adr[13:0];

    // State register and strobe/enable history
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
            stb_q <= 1'b0;
            enf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            stb_q <= stb;
            enf_q <= enf;
        end
    end

    // Next-state logic: one commit per I/O write regardless of its length
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stb && !stb_q) state_nxt = COMMIT;
            COMMIT:  state_nxt = stb ? HOLD : IDLE;
            HOLD:    if (!stb) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: capture strobe, register write enables, interrupt-clear pulse
    always_comb begin
        capture = 1'b0;
        rmr_wr  = 1'b0;
        rmr2_wr = 1'b0;
        int_clr = 1'b0;
        if (state == IDLE && stb && !stb_q) begin
            capture = 1'b1;
        end
        if (state == COMMIT) begin
            if (data_q[7:6] == 2'b10 && !(data_q[5] && feat_on)) begin
                rmr_wr  = 1'b1;
                int_clr = data_q[4];
            end
            if (data_q[7:5] == 3'b101 && feat_on) begin
                rmr2_wr = 1'b1;
            end
        end
    end

    // Write data and feature state captured on the clock entering COMMIT
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            data_q <= 8'h00;
            enf_s  <= 1'b0;
        end else if (capture) begin
            data_q <= data;
            enf_s  <= enf;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mode     <= 2'b00;
            lrom_dis <= 1'b0;
            urom_dis <= 1'b0;
        end else if (rmr_wr) begin
            mode     <= data_q[1:0];
            lrom_dis <= data_q[2];
            urom_dis <= data_q[3];
        end
    end

    // Locking forces RMR2 back to its reset value
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rmr2 <= RMR2_RESET;
        end else if (lock_edge) begin
            rmr2 <= RMR2_RESET;
        end else if (rmr2_wr) begin
            rmr2 <= data_q[4:0];
        end
    end

    assign asic_loc_hit = (rmr2[4:3] == ASIC_LOC);
    assign lrom_loc     = asic_loc_hit ? 2'b00 : rmr2[4:3];
    assign cart_page    = rmr2[2:0];
    assign asic_page_en = asic_loc_hit & enf;
    assign asic_cs      = asic_page_en & ~mreq_b & (adr[15:14] == 2'b01);

endmodule

// File: tb/tb_asic_rmr2_ctrl.sv
// Directed testbench for asic_rmr2_ctrl: RMR/RMR2 writes, held strobes, lock and reset.
module tb_asic_rmr2_ctrl;

    logic        clk;
    logic        reset_b;
    logic        ioreq_b;
    logic        wr_b;
    logic        mreq_b;
    logic [15:0] adr;
    logic [7:0]  data;
    logic        enf;
    logic [1:0]  mode;
    logic        lrom_dis;
    logic        urom_dis;
    logic        int_clr;
    logic [1:0]  lrom_loc;
    logic [2:0]  cart_page;
    logic        asic_page_en;
    logic        asic_cs;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    asic_rmr2_ctrl dut (
        .clk          (clk),
        .reset_b      (reset_b),
        .ioreq_b      (ioreq_b),
        .wr_b         (wr_b),
        .mreq_b       (mreq_b),
        .adr          (adr),
        .data         (data),
        .enf          (enf),
        .mode         (mode),
        .lrom_dis     (lrom_dis),
        .urom_dis     (urom_dis),
        .int_clr      (int_clr),
        .lrom_loc     (lrom_loc),
        .cart_page    (cart_page),
        .asic_page_en (asic_page_en),
        .asic_cs      (asic_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // int_clr pulses counted away from the active edge
    always @(negedge clk) if (int_clr === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_start(input logic [7:0] d);
        adr     = 16'h7F00;
        data    = d;
        ioreq_b = 1'b0;
        wr_b    = 1'b0;
    endtask

    task automatic io_end();
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        adr     = 16'h0000;
    endtask

    task automatic io_write(input logic [7:0] d, input int n);
        io_start(d);
        step(n);
        io_end();
        step(3);
    endtask

    task automatic chk_rmr(input string tag, input logic [1:0] m, input logic l, input logic u);
        chk({tag, ".mode"}, 16'(mode), 16'(m));
        chk({tag, ".lrom_dis"}, 16'(lrom_dis), 16'(l));
        chk({tag, ".urom_dis"}, 16'(urom_dis), 16'(u));
    endtask

    initial begin
        reset_b = 1'b0;
        ioreq_b = 1'b1;
        wr_b    = 1'b1;
        mreq_b  = 1'b1;
        adr     = 16'h0000;
        data    = 8'h00;
        enf     = 1'b0;
        step(2);
        chk_rmr("reset", 2'b00, 1'b0, 1'b0);
        chk("reset.int_clr", 16'(int_clr), 16'h0);
        chk("reset.lrom_loc", 16'(lrom_loc), 16'h0);
        chk("reset.cart_page", 16'(cart_page), 16'h0);
        chk("reset.asic_page_en", 16'(asic_page_en), 16'h0);
        chk("reset.asic_cs", 16'(asic_cs), 16'h0);
        reset_b = 1'b1;
        step(2);

        // 1: plain RMR write, no interrupt clear
        pulses = 0;
        io_write(8'h8D, 1);
        chk_rmr("t1", 2'b01, 1'b1, 1'b1);
        chk("t1.pulses", 16'(pulses), 16'd0);

        // 2: write held for 5 clocks commits once
        pulses = 0;
        io_write(8'h9C, 5);
        chk_rmr("t2", 2'b00, 1'b1, 1'b1);
        chk("t2.pulses", 16'(pulses), 16'd1);

        // pen/ink and reserved bytes are ignored
        io_write(8'h5F, 2);
        io_write(8'hC3, 2);
        chk_rmr("ign", 2'b00, 1'b1, 1'b1);

        // 3: locked, &A5 is an RMR write
        io_write(8'hA5, 1);
        chk_rmr("t3", 2'b01, 1'b1, 1'b0);
        chk("t3.lrom_loc", 16'(lrom_loc), 16'h0);
        chk("t3.cart_page", 16'(cart_page), 16'h0);

        // 4: unlocked RMR2 writes and ASIC page select
        enf = 1'b1;
        step(2);
        io_write(8'hB8, 1);
        chk("t4.asic_page_en", 16'(asic_page_en), 16'h1);
        chk("t4.lrom_loc", 16'(lrom_loc), 16'h0);
        chk_rmr("t4", 2'b01, 1'b1, 1'b0);
        mreq_b = 1'b0;
        adr    = 16'h4123;
        #1;
        chk("t4.asic_cs_4123", 16'(asic_cs), 16'h1);
        adr = 16'h8000;
        #1;
        chk("t4.asic_cs_8000", 16'(asic_cs), 16'h0);
        mreq_b = 1'b1;
        adr    = 16'h0000;
        io_write(8'hAB, 1);
        chk("t4.lrom_loc_ab", 16'(lrom_loc), 16'h1);
        chk("t4.cart_page_ab", 16'(cart_page), 16'h3);
        chk("t4.asic_page_en_ab", 16'(asic_page_en), 16'h0);
        chk_rmr("t4b", 2'b01, 1'b1, 1'b0);

        // 5: lock drops page enable at once, RMR2 clears on the next clock
        io_write(8'hBB, 1);
        chk("t5.asic_page_en_on", 16'(asic_page_en), 16'h1);
        chk("t5.cart_page_on", 16'(cart_page), 16'h3);
        enf = 1'b0;
        #1;
        chk("t5.asic_page_en_drop", 16'(asic_page_en), 16'h0);
        chk("t5.cart_page_before", 16'(cart_page), 16'h3);
        step(1);
        chk("t5.cart_page_after", 16'(cart_page), 16'h0);
        enf = 1'b1;
        #1;
        chk("t5.asic_page_en_relock", 16'(asic_page_en), 16'h0);
        chk_rmr("t5", 2'b01, 1'b1, 1'b0);
        enf = 1'b0;
        step(2);

        // 6: reset mid-write, write still active after release commits once
        pulses = 0;
        io_start(8'h8E);
        step(1);
        reset_b = 1'b0;
        #1;
        chk_rmr("t6.rst", 2'b00, 1'b0, 1'b0);
        chk("t6.rst.int_clr", 16'(int_clr), 16'h0);
        chk("t6.rst.cart_page", 16'(cart_page), 16'h0);
        step(2);
        reset_b = 1'b1;
        step(4);
        io_end();
        step(3);
        chk_rmr("t6", 2'b10, 1'b1, 1'b1);
        chk("t6.pulses", 16'(pulses), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
